fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 120 ++++++++++++
 tb/tb_fetch_stage.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage of a 5-stage in-order pipeline. It holds the PC,
// drives the instruction memory word address and registers the fetched word
// into the IF/ID pipeline register. The memory read is combinational, so an
// instruction fetched at PC p appears at the IF/ID outputs one edge later.
//
// Ports
//   clk_in         rising-edge clock
//   rst_in         synchronous active-high reset
//   stall_in       hold PC and IF/ID (load-use hazard)
//   flush_in       replace IF/ID contents with a bubble
//   redirect_in    load target_in into PC (taken branch/jump)
//   target_in      redirect target byte address
//   imem_addr_out  word address to instruction memory (pc_out[INDEX+1:2])
//   imem_data_in   instruction word returned by instruction memory
//   pc_out         PC currently being fetched
//   id_instr_out   IF/ID instruction
//   id_pc_out      IF/ID PC
//   id_pc4_out     IF/ID PC+4
//   id_valid_out   IF/ID holds a real instruction (0 = bubble)
//   misalign_out   one-cycle pulse: last redirect target had bits [1:0] != 0
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter int               WIDTH    = 32,
    parameter int               INDEX    = 5,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [WIDTH-1:0] NOP      = 32'h0000_0013
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             stall_in,
    input  logic             flush_in,
    input  logic             redirect_in,
    input  logic [WIDTH-1:0] target_in,
    output logic [INDEX-1:0] imem_addr_out,
    input  logic [WIDTH-1:0] imem_data_in,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] id_instr_out,
    output logic [WIDTH-1:0] id_pc_out,
    output logic [WIDTH-1:0] id_pc4_out,
    output logic             id_valid_out,
    output logic             misalign_out
);

    logic [WIDTH-1:0] pc_q,       pc_d;
    logic [WIDTH-1:0] id_instr_q, id_instr_d;
    logic [WIDTH-1:0] id_pc_q,    id_pc_d;
    logic [WIDTH-1:0] id_pc4_q,   id_pc4_d;
    logic             id_valid_q, id_valid_d;
    logic             misalign_q, misalign_d;

    logic [WIDTH-1:0] pc_plus4;

    // Wraps modulo 2^WIDTH by truncation, so 0xFFFF_FFFC + 4 = 0.
    assign pc_plus4 = pc_q + WIDTH'(4);

    // Next-PC: redirect wins over stall so a taken branch is never lost
    // behind a load-use bubble.
    // NOTE: always_comb assigns a default to every output first so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        pc_d       = pc_plus4;
        misalign_d = 1'b0;
        if (redirect_in) begin
            pc_d       = {target_in[WIDTH-1:2], 2'b00};
            misalign_d = (target_in[1:0] != 2'b00);
        end else if (stall_in) begin
            pc_d = pc_q;
        end
    end

    // IF/ID next state. A flush only squashes the instruction and valid bit;
    // the PC fields are left alone so the bubble still carries a sane PC.
    always_comb begin
        id_instr_d = id_instr_q;
        id_pc_d    = id_pc_q;
        id_pc4_d   = id_pc4_q;
        id_valid_d = id_valid_q;
        if (flush_in) begin
            id_instr_d = NOP;
            id_valid_d = 1'b0;
        end else if (!stall_in) begin
            id_instr_d = imem_data_in;
            id_pc_d    = pc_q;
            id_pc4_d   = pc_plus4;
            id_valid_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its _d value from before the edge, independent of block order.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pc_q       <= RESET_PC;
            id_instr_q <= NOP;
            id_pc_q    <= '0;
            id_pc4_q   <= '0;
            id_valid_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            id_instr_q <= id_instr_d;
            id_pc_q    <= id_pc_d;
            id_pc4_q   <= id_pc4_d;
            id_valid_q <= id_valid_d;
            misalign_q <= misalign_d;
        end
    end

    assign imem_addr_out = pc_q[INDEX+1:2];
    assign pc_out        = pc_q;
    assign id_instr_out  = id_instr_q;
    assign id_pc_out     = id_pc_q;
    assign id_pc4_out    = id_pc4_q;
    assign id_valid_out  = id_valid_q;
    assign misalign_out  = misalign_q;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed testbench for fetch_stage with WIDTH=32, INDEX=5. The instruction
// memory is a 32-word array with imem[i] = 32'h1000_0000 + i, read
// combinationally. Inputs are driven and outputs sampled 1 time unit after
// each rising edge.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    localparam int          WIDTH = 32;
    localparam int          INDEX = 5;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        stall_in;
    logic        flush_in;
    logic        redirect_in;
    logic [31:0] target_in;
    logic [4:0]  imem_addr_out;
    logic [31:0] imem_data_in;
    logic [31:0] pc_out;
    logic [31:0] id_instr_out;
    logic [31:0] id_pc_out;
    logic [31:0] id_pc4_out;
    logic        id_valid_out;
    logic        misalign_out;

    logic [31:0] imem [32];

    int passed = 0;
    int total  = 0;

    always #5 clk_in = ~clk_in;

    assign imem_data_in = imem[imem_addr_out];

    fetch_stage #(
        .WIDTH    (WIDTH),
        .INDEX    (INDEX),
        .RESET_PC (32'h0000_0000),
        .NOP      (NOP)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .stall_in      (stall_in),
        .flush_in      (flush_in),
        .redirect_in   (redirect_in),
        .target_in     (target_in),
        .imem_addr_out (imem_addr_out),
        .imem_data_in  (imem_data_in),
        .pc_out        (pc_out),
        .id_instr_out  (id_instr_out),
        .id_pc_out     (id_pc_out),
        .id_pc4_out    (id_pc4_out),
        .id_valid_out  (id_valid_out),
        .misalign_out  (misalign_out)
    );

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_inputs();
        rst_in      = 1'b0;
        stall_in    = 1'b0;
        flush_in    = 1'b0;
        redirect_in = 1'b0;
        target_in   = 32'h0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_in    = 1'b1;
        stall_in  = 1'b1;
        target_in = 32'h123;
        tick();
        tick();
        total++; if (pc_out !== 32'h0) $display("FAIL reset_pc got=%h exp=%h", pc_out, 32'h0); else passed++;
        total++; if (id_instr_out !== NOP) $display("FAIL reset_instr got=%h exp=%h", id_instr_out, NOP); else passed++;
        total++; if (id_pc_out !== 32'h0 || id_pc4_out !== 32'h0) $display("FAIL reset_idpc got=%h/%h exp=0/0", id_pc_out, id_pc4_out); else passed++;
        total++; if (id_valid_out !== 1'b0 || misalign_out !== 1'b0) $display("FAIL reset_flags got=%b/%b exp=0/0", id_valid_out, misalign_out); else passed++;
        total++; if (imem_addr_out !== 5'd0) $display("FAIL reset_addr got=%0d exp=0", imem_addr_out); else passed++;
        idle_inputs();
    endtask

    // Free run from reset: pc 0 -> 4 -> 8.
    task automatic test_sequential();
        tick();
        total++; if (pc_out !== 32'h4) $display("FAIL seq1_pc got=%h exp=%h", pc_out, 32'h4); else passed++;
        total++; if (id_instr_out !== 32'h1000_0000 || id_pc_out !== 32'h0 || id_pc4_out !== 32'h4 || id_valid_out !== 1'b1)
            $display("FAIL seq1_ifid got=%h/%h/%h/%b exp=10000000/0/4/1", id_instr_out, id_pc_out, id_pc4_out, id_valid_out); else passed++;
        tick();
        total++; if (pc_out !== 32'h8 || imem_addr_out !== 5'd2) $display("FAIL seq2_pc got=%h/%0d exp=8/2", pc_out, imem_addr_out); else passed++;
        total++; if (id_instr_out !== 32'h1000_0001 || id_pc_out !== 32'h4) $display("FAIL seq2_ifid got=%h/%h exp=10000001/4", id_instr_out, id_pc_out); else passed++;
    endtask

    // Two stalled cycles at pc=8, then resume without loss or duplication.
    task automatic test_stall();
        stall_in = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if (pc_out !== 32'h8 || id_pc_out !== 32'h4 || id_instr_out !== 32'h1000_0001 || id_valid_out !== 1'b1)
                $display("FAIL stall%0d got=%h/%h/%h/%b exp=8/4/10000001/1", i, pc_out, id_pc_out, id_instr_out, id_valid_out); else passed++;
        end
        stall_in = 1'b0;
        tick();
        total++; if (pc_out !== 32'hC || id_pc_out !== 32'h8 || id_pc4_out !== 32'hC || id_instr_out !== 32'h1000_0002)
            $display("FAIL stall_resume got=%h/%h/%h/%h exp=c/8/c/10000002", pc_out, id_pc_out, id_pc4_out, id_instr_out); else passed++;
    endtask

    // Redirect to 0x40 with flush at pc=12.
    task automatic test_redirect_flush();
        redirect_in = 1'b1;
        target_in   = 32'h40;
        flush_in    = 1'b1;
        tick();
        total++; if (pc_out !== 32'h40) $display("FAIL redir_pc got=%h exp=%h", pc_out, 32'h40); else passed++;
        total++; if (id_instr_out !== NOP || id_valid_out !== 1'b0) $display("FAIL redir_flush got=%h/%b exp=%h/0", id_instr_out, id_valid_out, NOP); else passed++;
        total++; if (id_pc_out !== 32'h8 || id_pc4_out !== 32'hC || misalign_out !== 1'b0)
            $display("FAIL redir_keep got=%h/%h/%b exp=8/c/0", id_pc_out, id_pc4_out, misalign_out); else passed++;
        idle_inputs();
        tick();
        total++; if (id_pc_out !== 32'h40 || id_instr_out !== 32'h1000_0010 || id_valid_out !== 1'b1 || pc_out !== 32'h44)
            $display("FAIL redir_next got=%h/%h/%b/%h exp=40/10000010/1/44", id_pc_out, id_instr_out, id_valid_out, pc_out); else passed++;
    endtask

    // Misaligned redirect while stalled: PC aligned, pulse one cycle, IF/ID held.
    task automatic test_misalign();
        redirect_in = 1'b1;
        target_in   = 32'h22;
        stall_in    = 1'b1;
        tick();
        total++; if (pc_out !== 32'h20) $display("FAIL mis_pc got=%h exp=%h", pc_out, 32'h20); else passed++;
        total++; if (misalign_out !== 1'b1) $display("FAIL mis_pulse got=%b exp=1", misalign_out); else passed++;
        total++; if (id_pc_out !== 32'h40 || id_pc4_out !== 32'h44 || id_instr_out !== 32'h1000_0010 || id_valid_out !== 1'b1)
            $display("FAIL mis_hold got=%h/%h/%h/%b exp=40/44/10000010/1", id_pc_out, id_pc4_out, id_instr_out, id_valid_out); else passed++;
        idle_inputs();
        tick();
        total++; if (misalign_out !== 1'b0) $display("FAIL mis_clear got=%b exp=0", misalign_out); else passed++;
        total++; if (pc_out !== 32'h24 || id_pc_out !== 32'h20 || id_instr_out !== 32'h1000_0008)
            $display("FAIL mis_next got=%h/%h/%h exp=24/20/10000008", pc_out, id_pc_out, id_instr_out); else passed++;
    endtask

    // A reset pulse that falls entirely between edges must be ignored.
    task automatic test_async_glitch();
        #2 rst_in = 1'b1;
        #2 rst_in = 1'b0;
        total++; if (pc_out !== 32'h24 || id_valid_out !== 1'b1) $display("FAIL glitch_now got=%h/%b exp=24/1", pc_out, id_valid_out); else passed++;
        tick();
        total++; if (pc_out !== 32'h28 || id_pc_out !== 32'h24) $display("FAIL glitch_edge got=%h/%h exp=28/24", pc_out, id_pc_out); else passed++;
    endtask

    // PC wrap from 0xFFFF_FFFC to 0 and imem index 31 -> 0.
    task automatic test_wrap();
        redirect_in = 1'b1;
        target_in   = 32'hFFFF_FFFC;
        tick();
        total++; if (pc_out !== 32'hFFFF_FFFC || imem_addr_out !== 5'd31) $display("FAIL wrap_top got=%h/%0d exp=fffffffc/31", pc_out, imem_addr_out); else passed++;
        idle_inputs();
        tick();
        total++; if (pc_out !== 32'h0 || imem_addr_out !== 5'd0) $display("FAIL wrap_pc got=%h/%0d exp=0/0", pc_out, imem_addr_out); else passed++;
        total++; if (id_pc_out !== 32'hFFFF_FFFC || id_pc4_out !== 32'h0 || id_instr_out !== 32'h1000_001F)
            $display("FAIL wrap_ifid got=%h/%h/%h exp=fffffffc/0/1000001f", id_pc_out, id_pc4_out, id_instr_out); else passed++;
    endtask

    // Reset overrides simultaneous stall and misaligned redirect.
    task automatic test_reset_override();
        stall_in    = 1'b1;
        redirect_in = 1'b1;
        target_in   = 32'h22;
        rst_in      = 1'b1;
        tick();
        total++; if (pc_out !== 32'h0 || id_valid_out !== 1'b0 || misalign_out !== 1'b0 || id_instr_out !== NOP)
            $display("FAIL rstov got=%h/%b/%b/%h exp=0/0/0/%h", pc_out, id_valid_out, misalign_out, id_instr_out, NOP); else passed++;
        idle_inputs();
        tick();
        total++; if (pc_out !== 32'h4 || id_pc_out !== 32'h0 || id_instr_out !== 32'h1000_0000 || id_valid_out !== 1'b1)
            $display("FAIL rstov_fetch got=%h/%h/%h/%b exp=4/0/10000000/1", pc_out, id_pc_out, id_instr_out, id_valid_out); else passed++;
    endtask

    // Flush while stalled squashes IF/ID but keeps PC and the PC fields.
    task automatic test_flush_stall();
        flush_in = 1'b1;
        stall_in = 1'b1;
        tick();
        total++; if (pc_out !== 32'h4) $display("FAIL fs_pc got=%h exp=4", pc_out); else passed++;
        total++; if (id_instr_out !== NOP || id_valid_out !== 1'b0 || id_pc_out !== 32'h0 || id_pc4_out !== 32'h4)
            $display("FAIL fs_ifid got=%h/%b/%h/%h exp=%h/0/0/4", id_instr_out, id_valid_out, id_pc_out, id_pc4_out, NOP); else passed++;
        idle_inputs();
        tick();
        total++; if (pc_out !== 32'h8 || id_pc_out !== 32'h4 || id_instr_out !== 32'h1000_0001 || id_valid_out !== 1'b1)
            $display("FAIL fs_next got=%h/%h/%h/%b exp=8/4/10000001/1", pc_out, id_pc_out, id_instr_out, id_valid_out); else passed++;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) imem[i] = 32'h1000_0000 + 32'(i);
        idle_inputs();
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_flush();
        test_misalign();
        test_async_glitch();
        test_wrap();
        test_reset_override();
        test_flush_stall();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
